// File: rtl/memory_wrapped_lat_if.sv
// slave_bus_if: request/bdone slave bus; ttype 0=READ 1=WRITE, tsize 0=BYTE 1=HALF 2=WORD.
interface slave_bus_if;
    logic        ss;
    logic        ttype;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  tsize;
    logic [31:0] rdata;
    logic        bdone;
    modport slave (input ss, ttype, addr, wdata, tsize, output rdata, bdone);
    modport master (output ss, ttype, addr, wdata, tsize, input rdata, bdone);
endinterface

// File: rtl/memory_wrapped_lat.sv
// memory_wrapped_lat: dual-port RAM with per-port wait states, ibus fetch and dbus load/store.
// Defining MEM_WRITE_PROTECT_EN adds a write-protected window [WP_BASE, WP_BASE+WP_SIZE) on dbus.
module memory_wrapped_lat #(
    parameter int N        = 1024,
    parameter int I_LAT    = 0,
    parameter int D_RD_LAT = 0,
    parameter int D_WR_LAT = 0
`ifdef MEM_WRITE_PROTECT_EN
    ,
    parameter int WP_BASE  = 0,
    parameter int WP_SIZE  = 256
`endif
) (
    input  logic       clk,
    input  logic       rst,
    slave_bus_if.slave ibus,
    slave_bus_if.slave dbus,
    output logic       ierr,
    output logic       derr
);
    localparam int AW = $clog2(N);
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    logic [31:0] mem [N/4];
    state_t is_q, is_d, ds_q, ds_d;
    logic [3:0] icnt_q, icnt_d, dcnt_q, dcnt_d;
    logic [AW-1:0] iaddr_q, iaddr_d, daddr_q, daddr_d;
    logic dwr_q, dwr_d, ierr_q, ierr_d, derr_q, derr_d;
    logic [1:0] dsize_q, dsize_d;
    logic [31:0] dwdata_q, dwdata_d, irdata_q, irdata_d, drdata_q, drdata_d;
    logic [31:0] wword, iword;
    logic [3:0] be;
    logic dwe, igo, dgo, dmis, dprot;

    always_comb begin
        is_d = is_q;
        icnt_d = icnt_q;
        iaddr_d = iaddr_q;
        if (is_q == IDLE && ibus.ss) begin
            iaddr_d = ibus.addr[AW-1:0];
            icnt_d = 4'(I_LAT);
            is_d = (I_LAT == 0) ? DONE : WAIT;
        end else if (is_q == WAIT) begin
            icnt_d = icnt_q - 4'd1;
            is_d = (icnt_q == 4'd1) ? DONE : WAIT;
        end else if (is_q == DONE) begin
            is_d = IDLE;
        end
    end

    always_comb begin
        ds_d = ds_q;
        dcnt_d = dcnt_q;
        daddr_d = daddr_q;
        dwr_d = dwr_q;
        dsize_d = dsize_q;
        dwdata_d = dwdata_q;
        if (ds_q == IDLE && dbus.ss) begin
            daddr_d = dbus.addr[AW-1:0];
            dwr_d = dbus.ttype;
            dsize_d = dbus.tsize;
            dwdata_d = dbus.wdata;
            dcnt_d = dbus.ttype ? 4'(D_WR_LAT) : 4'(D_RD_LAT);
            ds_d = (dcnt_d == 4'd0) ? DONE : WAIT;
        end else if (ds_q == WAIT) begin
            dcnt_d = dcnt_q - 4'd1;
            ds_d = (dcnt_q == 4'd1) ? DONE : WAIT;
        end else if (ds_q == DONE) begin
            ds_d = IDLE;
        end
    end

`ifdef MEM_WRITE_PROTECT_EN
    assign dprot = 32'(daddr_d) >= 32'(WP_BASE) && 32'(daddr_d) < 32'(WP_BASE + WP_SIZE);
`else
    assign dprot = 1'b0;
`endif

    // ibus data loaded on the write edge sees the dbus write merged in (read-after-write bypass)
    always_comb begin
        be = (dsize_q == SZ_BYTE) ? 4'b0001 << daddr_q[1:0] :
             (dsize_q == SZ_HALF) ? (daddr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wword = (dsize_q == SZ_BYTE) ? {4{dwdata_q[7:0]}} :
                (dsize_q == SZ_HALF) ? {2{dwdata_q[15:0]}} : dwdata_q;
        dwe = ds_q == DONE && dwr_q && !derr_q;
        iword = mem[iaddr_d[AW-1:2]];
        for (int b = 0; b < 4; b++)
            if (dwe && be[b] && daddr_q[AW-1:2] == iaddr_d[AW-1:2]) iword[8*b +: 8] = wword[8*b +: 8];
        igo = is_d == DONE && is_q != DONE;
        ierr_d = igo ? iaddr_d[1:0] != 2'b00 : ierr_q;
        irdata_d = igo ? (iaddr_d[1:0] != 2'b00 ? 32'h0 : iword) : irdata_q;
        dgo = ds_d == DONE && ds_q != DONE;
        dmis = (dsize_d == SZ_BYTE) ? 1'b0 : (dsize_d == SZ_HALF) ? daddr_d[0] : daddr_d[1:0] != 2'b00;
        derr_d = dgo ? dmis | (dwr_d & dprot) : derr_q;
        drdata_d = (dgo && !dwr_d) ? (dmis ? 32'h0 : mem[daddr_d[AW-1:2]]) : drdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_q <= IDLE;
            ds_q <= IDLE;
            icnt_q <= '0;
            dcnt_q <= '0;
            iaddr_q <= '0;
            daddr_q <= '0;
            dwr_q <= 1'b0;
            dsize_q <= '0;
            dwdata_q <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
            ierr_q <= 1'b0;
            derr_q <= 1'b0;
        end else begin
            is_q <= is_d;
            ds_q <= ds_d;
            icnt_q <= icnt_d;
            dcnt_q <= dcnt_d;
            iaddr_q <= iaddr_d;
            daddr_q <= daddr_d;
            dwr_q <= dwr_d;
            dsize_q <= dsize_d;
            dwdata_q <= dwdata_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
            ierr_q <= ierr_d;
            derr_q <= derr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && dwe)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[daddr_q[AW-1:2]][8*b +: 8] <= wword[8*b +: 8];
    end

    assign ibus.bdone = is_q == DONE;
    assign dbus.bdone = ds_q == DONE;
    assign ibus.rdata = irdata_q;
    assign dbus.rdata = drdata_q;
    assign ierr = is_q == DONE && ierr_q;
    assign derr = ds_q == DONE && derr_q;
endmodule

// File: tb/tb_memory_wrapped_lat.sv
// tb_memory_wrapped_lat: directed and random transactions checked against a byte-addressed memory model.
module tb_memory_wrapped_lat;
    localparam int N = 1024, I_LAT = 1, D_RD_LAT = 3, D_WR_LAT = 2;
    localparam logic [1:0] BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2;
    logic clk = 1'b0, rst = 1'b1, ierr, derr;
    int tests = 0, fails = 0;
    logic [7:0] mb [N];
    bit kn [N];
    logic [31:0] last_drd = 32'h0;
    bit last_kn = 1'b1;
    slave_bus_if ibus ();
    slave_bus_if dbus ();

    memory_wrapped_lat #(.N(N), .I_LAT(I_LAT), .D_RD_LAT(D_RD_LAT), .D_WR_LAT(D_WR_LAT)) dut (
        .clk(clk), .rst(rst), .ibus(ibus), .dbus(dbus), .ierr(ierr), .derr(derr));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic bit mis(input logic [1:0] sz, input logic [31:0] a);
        return (sz == HALF) ? (a % 2 != 0) : (sz == WORD) ? (a % 4 != 0) : 1'b0;
    endfunction

    function automatic bit prot(input logic [31:0] a);
`ifdef MEM_WRITE_PROTECT_EN
        return (a % N) < 256;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] word(input logic [31:0] a);
        int b = int'(a % N) / 4 * 4;
        return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
    endfunction

    function automatic bit known(input logic [31:0] a);
        int b = int'(a % N) / 4 * 4;
        return kn[b] && kn[b+1] && kn[b+2] && kn[b+3];
    endfunction

    task automatic mwrite(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int b = int'(a % N);
        int nb = (sz == BYTE) ? 1 : (sz == HALF) ? 2 : 4;
        for (int i = 0; i < nb; i++) begin
            mb[b+i] = wd[8*i +: 8];
            kn[b+i] = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic ixfer(input logic [31:0] a);
        int n = 0;
        ibus.ss = 1'b1;
        ibus.addr = a;
        ibus.tsize = 2'($urandom);
        ibus.ttype = 1'($urandom);
        ibus.wdata = $urandom;
        @(posedge clk);
        do begin
            @(negedge clk);
            n++;
        end while (!ibus.bdone && n < 40);
        chk("i_lat", n, 1 + I_LAT);
        chk("ierr", ierr, mis(WORD, a));
        if (mis(WORD, a)) chk("i_rdata_mis", ibus.rdata, 32'h0);
        else if (known(a)) chk("i_rdata", ibus.rdata, word(a));
        @(posedge clk);
        #1;
        ibus.ss = 1'b0;
    endtask

    task automatic dxfer(input logic wr, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int n = 0;
        bit bad = mis(sz, a);
        dbus.ss = 1'b1;
        dbus.ttype = wr;
        dbus.addr = a;
        dbus.tsize = sz;
        dbus.wdata = wd;
        @(posedge clk);
        do begin
            @(negedge clk);
            n++;
        end while (!dbus.bdone && n < 40);
        chk(wr ? "dw_lat" : "dr_lat", n, 1 + (wr ? D_WR_LAT : D_RD_LAT));
        chk("derr", derr, bad | (wr & prot(a)));
        if (!wr) begin
            last_kn = bad || known(a);
            last_drd = bad ? 32'h0 : word(a);
        end
        if (last_kn) chk(wr ? "d_rdata_hold" : "d_rdata", dbus.rdata, last_drd);
        @(posedge clk);
        #1;
        if (wr && !bad && !prot(a)) mwrite(a, sz, wd);
        dbus.ss = 1'b0;
    endtask

    initial begin
        ibus.ss = 1'b0; ibus.ttype = 1'b0; ibus.addr = '0; ibus.wdata = '0; ibus.tsize = WORD;
        dbus.ss = 1'b0; dbus.ttype = 1'b0; dbus.addr = '0; dbus.wdata = '0; dbus.tsize = WORD;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ibdone", ibus.bdone, 0);
        chk("rst_dbdone", dbus.bdone, 0);
        chk("rst_irdata", ibus.rdata, 32'h0);
        chk("rst_drdata", dbus.rdata, 32'h0);
        chk("rst_ierr", ierr, 0);
        chk("rst_derr", derr, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i += 4) dxfer(1'b1, i, WORD, 32'h0);
        // basic write then fetch
        dxfer(1'b1, 32'h10, WORD, 32'hDEADBEEF);
        ixfer(32'h10);
`ifndef MEM_WRITE_PROTECT_EN
        chk("t1_const", ibus.rdata, 32'hDEADBEEF);
`endif
        // read latency and single-cycle bdone
        dxfer(1'b0, 32'h10, WORD, 32'h0);
        @(negedge clk);
        chk("d_bdone_one", dbus.bdone, 0);
        @(posedge clk);
        #1;
        // lane writes
        dxfer(1'b1, 32'h20, WORD, 32'h11223344);
        dxfer(1'b1, 32'h21, BYTE, 32'h000000AA);
        dxfer(1'b1, 32'h22, HALF, 32'h0000BEEF);
        dxfer(1'b0, 32'h20, WORD, 32'h0);
`ifndef MEM_WRITE_PROTECT_EN
        chk("t3_const", dbus.rdata, 32'hBEEFAA44);
`endif
        // misalignment
        dxfer(1'b1, 32'h23, HALF, 32'h00001234);
        dxfer(1'b0, 32'h20, WORD, 32'h0);
        ixfer(32'h2);
        // same-cycle completion: ibus sees old data
        dxfer(1'b1, 32'h40, WORD, 32'h0);
        fork
            dxfer(1'b1, 32'h40, WORD, 32'h5A5A5A5A);
            begin
                @(posedge clk);
                #1;
                ixfer(32'h40);
            end
        join
        chk("t5_old", ibus.rdata, 32'h0);
        ixfer(32'h40);
        // fetch completing the cycle after the write sees the new data
        fork
            dxfer(1'b1, 32'h40, HALF, 32'h0000C3D2);
            begin
                repeat (2) @(posedge clk);
                #1;
                ixfer(32'h40);
            end
        join
        // aliasing of upper address bits
        dxfer(1'b1, 32'hFFFF_F050, WORD, 32'hCAFEF00D);
        ixfer(32'h0000_0050);
        dxfer(1'b0, 32'h1234_5450, WORD, 32'h0);
        repeat (200) begin
            int op = $urandom_range(0, 2);
            logic [1:0] sz = 2'($urandom_range(0, 2));
            logic [31:0] a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            if (op == 0) ixfer(a);
            else dxfer(op == 2, a, sz, $urandom);
        end
        // reset in the middle of a write wait
        dbus.ss = 1'b1; dbus.ttype = 1'b1; dbus.addr = 32'h10; dbus.tsize = WORD; dbus.wdata = 32'h12345678;
        @(posedge clk);
        #1;
        dbus.ss = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("rst_mid_bdone", dbus.bdone, 0);
        end
        chk("rst_mid_drdata", dbus.rdata, 32'h0);
        chk("rst_mid_irdata", ibus.rdata, 32'h0);
        last_drd = 32'h0;
        last_kn = 1'b1;
        @(posedge clk);
        #1;
        dxfer(1'b0, 32'h10, WORD, 32'h0);
        ixfer(32'h10);
        // write into the protectable window
        dxfer(1'b1, 32'h4, WORD, 32'h0);
        dxfer(1'b0, 32'h4, WORD, 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
